stopwatch_ctrl: RTL and testbench
=================================

// Module: stopwatch_ctrl
// PURPOSE
//  Control FSM for the stopwatch. Takes the debounced PAUSE, RESET, ADJ and SEL levels and drives the min:sec counter datapath with
//  one-cycle strobes: clear, second/minute increment, carry enable. Also produces the display blink enable.
//  Sits between the debouncer and the counter/display datapath; holds no time value itself.
// PARAMETERS
//  CLK_HZ    100_000_000  input clock frequency
//  RUN_HZ    1            count rate in RUN (sec_inc rate)
//  ADJ_HZ    2            increment rate of the selected field in ADJUST
//  BLINK_HZ  4            blink square-wave frequency, 50% duty
// PORTS
//  clk        in   1  system clock
//  rst        in   1  synchronous, active-high reset (debounced RESET)
//  pause      in   1  debounced PAUSE level; rising edge = press
//  adj        in   1  debounced ADJ switch level; 1 = adjust mode
//  sel        in   1  debounced SEL switch; 0 = seconds, 1 = minutes
//  clr        out  1  clear counter to 00:00
//  sec_inc    out  1  one-cycle strobe: increment seconds field
//  min_inc    out  1  one-cycle strobe: increment minutes field
//  carry_en   out  1  1 = seconds wrap 59->00 carries into minutes
//  running    out  1  1 while in RUN
//  blink_on   out  1  display enable for blinking
// BEHAVIOUR
//  - All outputs registered. While rst=1: state<=PAUSED, clr=1, sec_inc=min_inc=carry_en=running=0, blink_on=1, all dividers=0,
//    pause_q<=1 (press held through reset gives no edge). clr drops on the first clock with rst=0.
//  - States: RUN, PAUSED, ADJUST. saved_run flag records the RUN/PAUSED choice made while in ADJUST.
//    PAUSED --pause rise--> RUN; RUN --pause rise--> PAUSED.
//    RUN/PAUSED --adj=1--> ADJUST (saved_run<=running). ADJUST --adj=0--> RUN if saved_run else PAUSED.
//    Pause rise in ADJUST toggles saved_run; stays in ADJUST. adj takes priority over a simultaneous pause rise
//    (the rise then toggles saved_run).
//  - Run divider DIV_RUN=CLK_HZ/RUN_HZ: counts only in RUN, holds in PAUSED/ADJUST (fractional second kept).
//    sec_inc pulses once per DIV_RUN RUN cycles; first pulse DIV_RUN cycles after entering RUN from reset.
//    carry_en=1 in RUN, 0 otherwise.
//  - Adjust divider DIV_ADJ=CLK_HZ/ADJ_HZ: cleared on ADJUST entry and on any sel change; first strobe DIV_ADJ cycles later.
//    Each strobe pulses sec_inc (sel=0) or min_inc (sel=1), never both; carry_en=0, so fields wrap independently.
//  - Blink divider half-period CLK_HZ/(2*BLINK_HZ), free-running. blink_on toggles in ADJUST; forced 1 in RUN.
//  - sec_inc and min_inc never asserted together; neither asserted while clr=1.
//  - rst mid-operation: synchronous return to reset values on the next edge, regardless of state or divider phase.
//  - Divider widths are $clog2 of the divisor; divisors must be >=2 (elaboration error otherwise).
// CONFIGURATION
//  STOPWATCH_PAUSE_BLINK_EN defined: in PAUSED, blink_on toggles with the blink divider (whole display flashes).
//  Not defined: blink_on=1 in PAUSED. ADJUST and RUN behaviour identical either way.
// STRUCTURE
//  stopwatch_pkg holds:
//   - state enum (RUN, PAUSED, ADJUST)
//   - divisor constants/function div_of(CLK_HZ, HZ)
//   - FIELD_SEC/FIELD_MIN encodings
//  Sub-module tick_divider #(DIV), 3 instances (run, adj, blink).
//   - ports: clk, rst, en, clr, tick; tick is one cycle when count==DIV-1 && en.
// TESTING  (CLK_HZ=16, RUN_HZ=1, ADJ_HZ=2, BLINK_HZ=4)
//  1. Reset 3 cycles, release -> clr=1 during reset, 0 on 1st clock after; running=0, no strobes for 40 cycles.
//  2. Pause rise -> running=1 next cycle; sec_inc every 16 cycles, carry_en=1.
//     2nd rise after 24 cycles -> running=0, strobes stop.
//     3rd rise -> next sec_inc 8 cycles later (phase held).
//  3. adj=1, sel=1 -> carry_en=0; min_inc every 8 cycles, no sec_inc.
//     Flip sel=0 mid-period -> next sec_inc exactly 8 cycles after the flip.
//  4. In RUN raise adj, pulse pause, drop adj -> returns to PAUSED; with no pause pulse, returns to RUN.
//  5. pause held high across reset -> no transition after release; release then press -> RUN.
//  6. blink_on in ADJUST: period 4 cycles, 2 high / 2 low. In PAUSED: 1, or toggles when STOPWATCH_PAUSE_BLINK_EN is set.

Source files
------------

// File: rtl/stopwatch_pkg.sv
// Shared types and constants for the stopwatch control block.
package stopwatch_pkg;

    typedef enum logic [1:0] {
        ST_RUN    = 2'd0,
        ST_PAUSED = 2'd1,
        ST_ADJUST = 2'd2
    } state_t;

    localparam logic FIELD_SEC = 1'b0;
    localparam logic FIELD_MIN = 1'b1;

    function automatic int div_of(input int clk_hz, input int hz);
        return clk_hz / hz;
    endfunction

endpackage

// File: rtl/stopwatch_tick_divider.sv
// Divide-by-DIV strobe: tick_o is high for one cycle when the count reaches DIV-1 while en_i is set.
// clr_i overrides en_i; the count holds while en_i is low.
module tick_divider #(
    parameter int DIV = 2
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic en_i,
    input  logic clr_i,
    output logic tick_o
);
    localparam int W = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [W-1:0] LAST = W'(DIV - 1);

    logic [W-1:0] count_q, count_d;

    if (DIV < 2) begin : g_div_check
        $error("tick_divider: DIV must be >= 2");
    end

    assign tick_o = en_i && (count_q == LAST);

    always_comb begin
        count_d = count_q;
        if (clr_i) begin
            count_d = '0;
        end else if (en_i) begin
            count_d = tick_o ? '0 : count_q + W'(1);
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

endmodule

// File: rtl/stopwatch_ctrl.sv
// Stopwatch control FSM: turns debounced PAUSE/ADJ/SEL levels into registered clear/increment strobes and blink enable.
// STOPWATCH_PAUSE_BLINK_EN: when defined, the display also blinks while PAUSED.
module stopwatch_ctrl
    import stopwatch_pkg::*;
#(
    parameter int CLK_HZ   = 100_000_000,
    parameter int RUN_HZ   = 1,
    parameter int ADJ_HZ   = 2,
    parameter int BLINK_HZ = 4
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic pause_i,
    input  logic adj_i,
    input  logic sel_i,
    output logic clr_o,
    output logic sec_inc_o,
    output logic min_inc_o,
    output logic carry_en_o,
    output logic running_o,
    output logic blink_on_o
);
    localparam int DIV_RUN   = div_of(CLK_HZ, RUN_HZ);
    localparam int DIV_ADJ   = div_of(CLK_HZ, ADJ_HZ);
    localparam int DIV_BLINK = div_of(CLK_HZ, 2 * BLINK_HZ);

    state_t state_q, state_d;
    logic   saved_run_q, saved_run_d;
    logic   pause_q, sel_q;
    logic   blink_ph_q, blink_ph_d;
    logic   clr_q, sec_inc_q, min_inc_q, carry_en_q, running_q, blink_on_q;
    logic   sec_inc_d, min_inc_d, carry_en_d, running_d, blink_on_d;
    logic   pause_rise, sel_chg, adj_entry, adj_fire;
    logic   run_tick, adj_tick, blink_tick;

    assign pause_rise = pause_i & ~pause_q;
    assign sel_chg    = sel_i ^ sel_q;

    always_comb begin
        state_d     = state_q;
        saved_run_d = saved_run_q;
        case (state_q)
            ST_RUN, ST_PAUSED: begin
                // adj wins; a coincident press still flips the run/pause choice
                if (adj_i) begin
                    state_d     = ST_ADJUST;
                    saved_run_d = (state_q == ST_RUN) ^ pause_rise;
                end else if (pause_rise) begin
                    state_d = (state_q == ST_RUN) ? ST_PAUSED : ST_RUN;
                end
            end
            ST_ADJUST: begin
                if (pause_rise) begin
                    saved_run_d = ~saved_run_q;
                end
                if (!adj_i) begin
                    state_d = saved_run_d ? ST_RUN : ST_PAUSED;
                end
            end
            default: state_d = ST_PAUSED;
        endcase
    end

    assign adj_entry = (state_d == ST_ADJUST) && (state_q != ST_ADJUST);

    tick_divider #(.DIV(DIV_RUN)) u_run_div (
        .clk_i (clk_i),
        .rst_i (rst_i),
        .en_i  (state_q == ST_RUN),
        .clr_i (1'b0),
        .tick_o(run_tick)
    );

    tick_divider #(.DIV(DIV_ADJ)) u_adj_div (
        .clk_i (clk_i),
        .rst_i (rst_i),
        .en_i  (state_q == ST_ADJUST),
        .clr_i (adj_entry | sel_chg),
        .tick_o(adj_tick)
    );

    tick_divider #(.DIV(DIV_BLINK)) u_blink_div (
        .clk_i (clk_i),
        .rst_i (rst_i),
        .en_i  (1'b1),
        .clr_i (1'b0),
        .tick_o(blink_tick)
    );

    always_comb begin
        // a tick landing on a sel change belongs to the old field's period; drop it
        adj_fire   = adj_tick && !sel_chg;
        sec_inc_d  = run_tick || (adj_fire && (sel_i == FIELD_SEC));
        min_inc_d  = adj_fire && (sel_i == FIELD_MIN);
        carry_en_d = (state_d == ST_RUN);
        running_d  = (state_d == ST_RUN);
        blink_ph_d = blink_tick ? ~blink_ph_q : blink_ph_q;
        blink_on_d = 1'b1;
        case (state_d)
            ST_ADJUST: blink_on_d = blink_ph_d;
`ifdef STOPWATCH_PAUSE_BLINK_EN
            ST_PAUSED: blink_on_d = blink_ph_d;
`else
            ST_PAUSED: blink_on_d = 1'b1;
`endif
            default:   blink_on_d = 1'b1;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q     <= ST_PAUSED;
            saved_run_q <= 1'b0;
            pause_q     <= 1'b1;
            sel_q       <= sel_i;
            blink_ph_q  <= 1'b1;
            clr_q       <= 1'b1;
            sec_inc_q   <= 1'b0;
            min_inc_q   <= 1'b0;
            carry_en_q  <= 1'b0;
            running_q   <= 1'b0;
            blink_on_q  <= 1'b1;
        end else begin
            state_q     <= state_d;
            saved_run_q <= saved_run_d;
            pause_q     <= pause_i;
            sel_q       <= sel_i;
            blink_ph_q  <= blink_ph_d;
            clr_q       <= 1'b0;
            sec_inc_q   <= sec_inc_d;
            min_inc_q   <= min_inc_d;
            carry_en_q  <= carry_en_d;
            running_q   <= running_d;
            blink_on_q  <= blink_on_d;
        end
    end

    assign clr_o      = clr_q;
    assign sec_inc_o  = sec_inc_q;
    assign min_inc_o  = min_inc_q;
    assign carry_en_o = carry_en_q;
    assign running_o  = running_q;
    assign blink_on_o = blink_on_q;

endmodule

// File: tb/tb_stopwatch_ctrl.sv
// Directed bench for stopwatch_ctrl at CLK_HZ=16: run divisor 16, adjust divisor 8, blink half-period 2.
module tb_stopwatch_ctrl;
    logic clk = 1'b0;
    logic rst, pause, adj, sel;
    logic clr, sec_inc, min_inc, carry_en, running, blink_on;
    int   n_checks = 0;
    int   n_fail   = 0;

    always #5 clk = ~clk;

    stopwatch_ctrl #(
        .CLK_HZ  (16),
        .RUN_HZ  (1),
        .ADJ_HZ  (2),
        .BLINK_HZ(4)
    ) dut (
        .clk_i     (clk),
        .rst_i     (rst),
        .pause_i   (pause),
        .adj_i     (adj),
        .sel_i     (sel),
        .clr_o     (clr),
        .sec_inc_o (sec_inc),
        .min_inc_o (min_inc),
        .carry_en_o(carry_en),
        .running_o (running),
        .blink_on_o(blink_on)
    );

    // Advance n rising edges; inputs are driven and outputs sampled 1 time unit after each edge.
    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic test_reset();
        int strobes, runs;
        rst = 1'b1; pause = 1'b0; adj = 1'b0; sel = 1'b0;
        step(3);
        n_checks++;
        if ({clr, sec_inc, min_inc, carry_en, running, blink_on} !== 6'b100001) begin
            n_fail++;
            $display("FAIL reset_outputs: got %b want 100001", {clr, sec_inc, min_inc, carry_en, running, blink_on});
        end
        rst = 1'b0;
        step(1);
        n_checks++;
        if (clr !== 1'b0) begin n_fail++; $display("FAIL clr_release: got %b want 0", clr); end
        strobes = 0; runs = 0;
        for (int k = 0; k < 40; k++) begin
            step(1);
            strobes += int'(sec_inc) + int'(min_inc);
            runs    += int'(running);
        end
        n_checks++;
        if (strobes !== 0) begin n_fail++; $display("FAIL idle_strobes: got %0d want 0", strobes); end
        n_checks++;
        if (runs !== 0) begin n_fail++; $display("FAIL idle_running: got %0d want 0", runs); end
    endtask

    task automatic test_run();
        int first, cnt, strobes, runs;
        pause = 1'b1;
        step(1);
        n_checks++;
        if (running !== 1'b1) begin n_fail++; $display("FAIL run_enter: got %b want 1", running); end
        n_checks++;
        if (carry_en !== 1'b1) begin n_fail++; $display("FAIL run_carry: got %b want 1", carry_en); end
        pause = 1'b0;
        first = -1; cnt = 0;
        for (int k = 1; k <= 24; k++) begin
            step(1);
            if (sec_inc === 1'b1) begin cnt++; if (first < 0) first = k; end
            if (k == 23) pause = 1'b1;
        end
        n_checks++;
        if (first !== 16) begin n_fail++; $display("FAIL run_first_sec: got %0d want 16", first); end
        n_checks++;
        if (cnt !== 1) begin n_fail++; $display("FAIL run_sec_count: got %0d want 1", cnt); end
        n_checks++;
        if (running !== 1'b0) begin n_fail++; $display("FAIL pause_enter: got %b want 0", running); end
        pause = 1'b0;
        strobes = 0; runs = 0;
        for (int k = 0; k < 20; k++) begin
            step(1);
            strobes += int'(sec_inc) + int'(min_inc) + int'(carry_en);
            runs    += int'(running);
        end
        n_checks++;
        if (strobes !== 0 || runs !== 0) begin
            n_fail++;
            $display("FAIL paused_quiet: got strobes=%0d running=%0d want 0 0", strobes, runs);
        end
        pause = 1'b1;
        step(1);
        pause = 1'b0;
        first = -1;
        for (int k = 1; k <= 8; k++) begin
            step(1);
            if (sec_inc === 1'b1 && first < 0) first = k;
        end
        n_checks++;
        if (first !== 8) begin n_fail++; $display("FAIL resume_phase: got %0d want 8", first); end
    endtask

    task automatic test_adjust();
        logic [31:0] mmask;
        int secs, mins, first;
        adj = 1'b1; sel = 1'b1;
        step(1);
        n_checks++;
        if (carry_en !== 1'b0 || running !== 1'b0) begin
            n_fail++;
            $display("FAIL adj_enter: got carry=%b running=%b want 0 0", carry_en, running);
        end
        mmask = '0; secs = 0;
        for (int k = 1; k <= 24; k++) begin
            step(1);
            if (min_inc === 1'b1) mmask[k] = 1'b1;
            secs += int'(sec_inc);
        end
        n_checks++;
        if (mmask !== 32'h0101_0100) begin n_fail++; $display("FAIL adj_min_pos: got %h want 01010100", mmask); end
        n_checks++;
        if (secs !== 0) begin n_fail++; $display("FAIL adj_no_sec: got %0d want 0", secs); end
        step(3);
        sel = 1'b0;
        step(1);
        first = -1; mins = 0;
        for (int k = 1; k <= 12; k++) begin
            step(1);
            if (sec_inc === 1'b1 && first < 0) first = k;
            mins += int'(min_inc);
        end
        n_checks++;
        if (first !== 8) begin n_fail++; $display("FAIL sel_flip_sec: got %0d want 8", first); end
        n_checks++;
        if (mins !== 0) begin n_fail++; $display("FAIL sel_flip_min: got %0d want 0", mins); end
    endtask

    task automatic test_return();
        int strobes;
        adj = 1'b0;
        step(1);
        n_checks++;
        if (running !== 1'b1 || carry_en !== 1'b1) begin
            n_fail++;
            $display("FAIL return_run: got running=%b carry=%b want 1 1", running, carry_en);
        end
        adj = 1'b1;
        step(1);
        n_checks++;
        if (running !== 1'b0) begin n_fail++; $display("FAIL run_to_adj: got %b want 0", running); end
        pause = 1'b1; step(1);
        pause = 1'b0; step(1);
        adj = 1'b0; step(1);
        n_checks++;
        if (running !== 1'b0) begin n_fail++; $display("FAIL return_paused: got %b want 0", running); end
        strobes = 0;
        for (int k = 0; k < 20; k++) begin
            step(1);
            strobes += int'(sec_inc) + int'(min_inc) + int'(running);
        end
        n_checks++;
        if (strobes !== 0) begin n_fail++; $display("FAIL paused_not_adjust: got %0d want 0", strobes); end
        adj = 1'b1; pause = 1'b1;
        step(1);
        n_checks++;
        if (running !== 1'b0) begin n_fail++; $display("FAIL adj_priority: got %b want 0", running); end
        pause = 1'b0; step(1);
        adj = 1'b0; step(1);
        n_checks++;
        if (running !== 1'b1) begin n_fail++; $display("FAIL coincident_toggle: got %b want 1", running); end
    endtask

    task automatic test_blink();
        logic s [8];
        int ones;
        ones = 0;
        for (int k = 0; k < 8; k++) begin step(1); ones += int'(blink_on); end
        n_checks++;
        if (ones !== 8) begin n_fail++; $display("FAIL blink_run: got %0d highs want 8", ones); end
        adj = 1'b1;
        step(1);
        for (int k = 0; k < 8; k++) begin s[k] = blink_on; if (k < 7) step(1); end
        for (int k = 0; k < 6; k++) begin
            n_checks++;
            if (s[k+2] !== ~s[k]) begin n_fail++; $display("FAIL blink_adj_%0d: got %b want %b", k, s[k+2], ~s[k]); end
        end
        adj = 1'b0; step(1);
        pause = 1'b1; step(1);
        pause = 1'b0;
        n_checks++;
        if (running !== 1'b0) begin n_fail++; $display("FAIL blink_pause_enter: got %b want 0", running); end
        ones = 0;
        for (int k = 0; k < 8; k++) begin step(1); s[k] = blink_on; ones += int'(blink_on); end
`ifdef STOPWATCH_PAUSE_BLINK_EN
        for (int k = 0; k < 6; k++) begin
            n_checks++;
            if (s[k+2] !== ~s[k]) begin n_fail++; $display("FAIL blink_paused_%0d: got %b want %b", k, s[k+2], ~s[k]); end
        end
`else
        n_checks++;
        if (ones !== 8) begin n_fail++; $display("FAIL blink_paused: got %0d highs want 8", ones); end
`endif
    endtask

    task automatic test_reset_mid();
        int runs, first;
        pause = 1'b1; step(1);
        pause = 1'b0; step(5);
        rst = 1'b1; step(1);
        n_checks++;
        if ({clr, sec_inc, min_inc, carry_en, running, blink_on} !== 6'b100001) begin
            n_fail++;
            $display("FAIL reset_mid: got %b want 100001", {clr, sec_inc, min_inc, carry_en, running, blink_on});
        end
        pause = 1'b1; step(2);
        rst = 1'b0;
        runs = 0;
        for (int k = 0; k < 10; k++) begin step(1); runs += int'(running); end
        n_checks++;
        if (runs !== 0) begin n_fail++; $display("FAIL held_pause_no_edge: got %0d want 0", runs); end
        pause = 1'b0; step(2);
        pause = 1'b1; step(1);
        n_checks++;
        if (running !== 1'b1) begin n_fail++; $display("FAIL press_after_reset: got %b want 1", running); end
        pause = 1'b0;
        first = -1;
        for (int k = 1; k <= 20; k++) begin
            step(1);
            if (sec_inc === 1'b1 && first < 0) first = k;
        end
        n_checks++;
        if (first !== 16) begin n_fail++; $display("FAIL post_reset_phase: got %0d want 16", first); end
    endtask

    initial begin
        test_reset();
        test_run();
        test_adjust();
        test_return();
        test_blink();
        test_reset_mid();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
